// File: rtl/board_pixel_renderer.sv
// board_pixel_renderer
// Pixel-colour stage between the VGA timing counter and the DAC pins. The live
// h/v counters are mapped onto a CELLS x CELLS board of CELL_PX-square cells.
// The 2-bit cell code is fetched from board RAM and turned into an RGB332
// colour. Sync and counter values are delayed so they stay aligned with rgb.
//
// Two pixel ticks of latency (all state advances only on pix_en):
//   S1: classify the pixel (outside / border / board), advance the cell
//       counters, and issue a one-clock board RAM read for board pixels.
//   S2: register the colour from cell_data and the S1 class.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   pix_en               one-clock strobe per pixel
//   h_counter, v_counter live pixel position from the timing generator
//   hsync_in, vsync_in   raw syncs from the timing generator
//   cell_rd_en           board RAM read strobe (one clock per board pixel)
//   cell_addr            board RAM address, row*CELLS + col
//   cell_data            board RAM data, valid one clock after cell_rd_en
//   rgb                  RGB332 pixel colour
//   Hsync, Vsync         syncs delayed to match rgb
//   h_out, v_out         counters delayed to match rgb
//
// Build option: define GRID_LINES_EN to draw grey-ish grid lines on the first
// column/line of every empty cell. Latency and interface are unchanged.

module board_pixel_renderer #(
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515,
    parameter int H_BRD_START = 224,
    parameter int V_BRD_START = 35,
    parameter int CELLS       = 30,
    parameter int CELL_PX     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic       cell_rd_en,
    output logic [9:0] cell_addr,
    input  logic [1:0] cell_data,
    output logic [7:0] rgb,
    output logic       Hsync,
    output logic       Vsync,
    output logic [9:0] h_out,
    output logic [9:0] v_out
);

    localparam int BRD_PX = CELLS * CELL_PX;
    localparam int SUB_W  = $clog2(CELL_PX);

    localparam logic [9:0] HVS = 10'(H_VIS_START);
    localparam logic [9:0] HVE = 10'(H_VIS_END);
    localparam logic [9:0] VVS = 10'(V_VIS_START);
    localparam logic [9:0] VVE = 10'(V_VIS_END);
    localparam logic [9:0] HBS = 10'(H_BRD_START);
    localparam logic [9:0] HBE = 10'(H_BRD_START + BRD_PX);
    localparam logic [9:0] VBS = 10'(V_BRD_START);
    localparam logic [9:0] VBE = 10'(V_BRD_START + BRD_PX);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);
    localparam logic [4:0]       CELL_LAST = 5'(CELLS - 1);
    localparam logic [9:0]       ROW_STEP  = 10'(CELLS);

    localparam logic [7:0] C_BLACK = 8'h00;
    localparam logic [7:0] C_BLUE  = 8'h03;
    localparam logic [7:0] C_RED   = 8'hE0;
    localparam logic [7:0] C_GREEN = 8'h1C;
    localparam logic [7:0] C_GRAY  = 8'h92;
`ifdef GRID_LINES_EN
    localparam logic [7:0] C_GRID  = 8'h49;
`endif

    typedef enum logic [1:0] {
        CLS_OUT    = 2'd0,
        CLS_BORDER = 2'd1,
        CLS_BOARD  = 2'd2
    } pix_class_t;

    // Column/row position of the board cell being scanned.
    logic [SUB_W-1:0] sub_x;
    logic [4:0]       col;
    logic [SUB_W-1:0] sub_y;
    logic [4:0]       row;
    logic [9:0]       row_base;

    // S1 pipeline registers
    pix_class_t s1_class;
    logic       s1_hs;
    logic       s1_vs;
    logic [9:0] s1_h;
    logic [9:0] s1_v;
`ifdef GRID_LINES_EN
    logic       s1_grid;
`endif

    logic             visible;
    logic             on_board;
    logic             col_start;
    logic [SUB_W-1:0] cur_sub_x;
    logic [4:0]       cur_col;
    pix_class_t       pix_class;
    logic [7:0]       colour;

    assign visible  = (h_counter >= HVS) && (h_counter < HVE) &&
                      (v_counter >= VVS) && (v_counter < VVE);
    assign on_board = (h_counter >= HBS) && (h_counter < HBE) &&
                      (v_counter >= VBS) && (v_counter < VBE);

    // The registered column counters describe the pixel *after* the one just
    // classified; at the first board column they are forced to zero so the
    // current pixel already addresses cell 0.
    assign col_start = (h_counter == HBS);
    assign cur_sub_x = col_start ? '0 : sub_x;
    assign cur_col   = col_start ? '0 : col;

    always_comb begin
        pix_class = CLS_OUT;
        if (on_board) begin
            pix_class = CLS_BOARD;
        end else if (visible) begin
            pix_class = CLS_BORDER;
        end
    end

    always_comb begin
        colour = C_BLACK;
        case (s1_class)
            CLS_BORDER: colour = C_GRAY;
            CLS_BOARD: begin
                case (cell_data)
                    2'd1:    colour = C_BLUE;
                    2'd2:    colour = C_RED;
                    2'd3:    colour = C_GREEN;
                    default: colour = C_BLACK;
                endcase
`ifdef GRID_LINES_EN
                if ((cell_data == 2'd0) && s1_grid) begin
                    colour = C_GRID;
                end
`endif
            end
            default: colour = C_BLACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_x      <= '0;
            col        <= '0;
            sub_y      <= '0;
            row        <= '0;
            row_base   <= '0;
            cell_rd_en <= 1'b0;
            cell_addr  <= '0;
            s1_class   <= CLS_OUT;
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s1_h       <= '0;
            s1_v       <= '0;
`ifdef GRID_LINES_EN
            s1_grid    <= 1'b0;
`endif
            rgb        <= C_BLACK;
            Hsync      <= 1'b1;
            Vsync      <= 1'b1;
            h_out      <= '0;
            v_out      <= '0;
        end else if (pix_en) begin
            // S1: column counters; col saturates past the right board edge
            sub_x <= cur_sub_x + 1'b1;
            if ((cur_sub_x == SUB_LAST) && (cur_col != CELL_LAST)) begin
                col <= cur_col + 5'd1;
            end else begin
                col <= cur_col;
            end

            // S1: row counters step once per line at h==0; row_base tracks
            // row*CELLS by accumulation. Re-locks at the top board line.
            if (h_counter == 10'd0) begin
                if (v_counter == VBS) begin
                    sub_y    <= '0;
                    row      <= '0;
                    row_base <= '0;
                end else begin
                    sub_y <= sub_y + 1'b1;
                    if ((sub_y == SUB_LAST) && (row != CELL_LAST)) begin
                        row      <= row + 5'd1;
                        row_base <= row_base + ROW_STEP;
                    end
                end
            end

            cell_rd_en <= on_board;
            if (on_board) begin
                cell_addr <= row_base + {5'd0, cur_col};
            end

            s1_class <= pix_class;
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
            s1_h     <= h_counter;
            s1_v     <= v_counter;
`ifdef GRID_LINES_EN
            s1_grid  <= (cur_sub_x == '0) || (sub_y == '0);
`endif

            // S2
            rgb   <= colour;
            Hsync <= s1_hs;
            Vsync <= s1_vs;
            h_out <= s1_h;
            v_out <= s1_v;
        end else begin
            cell_rd_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_board_pixel_renderer.sv
module tb_board_pixel_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic [9:0] h_counter;
    logic [9:0] v_counter;
    logic       hsync_in;
    logic       vsync_in;
    logic       cell_rd_en;
    logic [9:0] cell_addr;
    logic [1:0] cell_data = 2'b00;
    logic [7:0] rgb;
    logic       Hsync;
    logic       Vsync;
    logic [9:0] h_out;
    logic [9:0] v_out;

    board_pixel_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .h_counter  (h_counter),
        .v_counter  (v_counter),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .cell_rd_en (cell_rd_en),
        .cell_addr  (cell_addr),
        .cell_data  (cell_data),
        .rgb        (rgb),
        .Hsync      (Hsync),
        .Vsync      (Vsync),
        .h_out      (h_out),
        .v_out      (v_out)
    );

    always #5 clk = ~clk;

    // Board RAM: registered read, data one clock after the strobe.
    logic [1:0] ram [900];
    always @(posedge clk) begin
        if (cell_rd_en) cell_data <= (cell_addr < 10'd900) ? ram[cell_addr] : 2'b00;
    end

    int total = 0;
    int bad   = 0;
    int period = 4;

    // Expectation for the pixel driven on the previous tick.
    bit         pend_chk = 0;
    logic [7:0] pend_rgb;
    logic       pend_hs, pend_vs;
    int         pend_h, pend_v;

    typedef struct {
        int         h;
        int         v;
        int         phase;
        logic [7:0] rgb;
        bit         rd;
        int         addr;
    } vec_t;
    localparam int NV = 10;
    vec_t tbl [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp,
                         input int h, input int v);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at h=%0d v=%0d: got %0h want %0h", nm, h, v, act, exp);
        end
    endtask

    // Reference: colour straight from the screen geometry and the RAM image.
    function automatic void model(input int h, input int v, output logic [7:0] c,
                                  output bit rd, output int addr);
        int code;
        c = 8'h00; rd = 0; addr = 0;
        if (h >= 144 && h < 784 && v >= 35 && v < 515) c = 8'h92;
        if (h >= 224 && h < 704 && v >= 35 && v < 515) begin
            rd   = 1;
            addr = ((v - 35) / 16) * 30 + (h - 224) / 16;
            code = int'(ram[addr]);
            case (code)
                1: c = 8'h03;
                2: c = 8'hE0;
                3: c = 8'h1C;
                default: c = 8'h00;
            endcase
`ifdef GRID_LINES_EN
            if (code == 0 && (((h - 224) % 16) == 0 || ((v - 35) % 16) == 0)) c = 8'h49;
`endif
        end
    endfunction

    // One pixel tick. Checks the outputs of the previous tick's pixel and the
    // read strobe / address of this one.
    task automatic pix(input int h, input int v, input bit chk, input int phase);
        logic [7:0] e_rgb;
        bit         e_rd;
        int         e_addr;
        model(h, v, e_rgb, e_rd, e_addr);
        if (phase >= 0) begin
            for (int i = 0; i < NV; i++) begin
                if (tbl[i].h == h && tbl[i].v == v && tbl[i].phase == phase) begin
                    e_rgb = tbl[i].rgb; e_rd = tbl[i].rd; e_addr = tbl[i].addr;
                end
            end
        end
        @(negedge clk);
        h_counter = 10'(h);
        v_counter = 10'(v);
        hsync_in  = (h >= 96);
        vsync_in  = (v >= 2);
        pix_en    = 1'b1;
        @(posedge clk);
        #1;
        if (pend_chk) begin
            check("rgb",   {24'd0, rgb},   {24'd0, pend_rgb}, pend_h, pend_v);
            check("hsync", {31'd0, Hsync}, {31'd0, pend_hs},  pend_h, pend_v);
            check("vsync", {31'd0, Vsync}, {31'd0, pend_vs},  pend_h, pend_v);
            check("h_out", {22'd0, h_out}, pend_h,            pend_h, pend_v);
            check("v_out", {22'd0, v_out}, pend_v,            pend_h, pend_v);
        end
        if (chk) begin
            check("rd_en", {31'd0, cell_rd_en}, {31'd0, e_rd}, h, v);
            if (e_rd) check("addr", {22'd0, cell_addr}, e_addr, h, v);
        end
        pend_chk = chk;
        pend_rgb = e_rgb;
        pend_hs  = (h >= 96);
        pend_vs  = (v >= 2);
        pend_h   = h;
        pend_v   = v;
        @(negedge clk);
        pix_en = 1'b0;
        if (chk && e_rd) begin
            @(posedge clk);
            #1;
            check("rd_pulse", {31'd0, cell_rd_en}, 32'd0, h, v);
        end
        repeat (period - 2) @(negedge clk);
    endtask

    // mode 0: directed lines; 1: every board row; 2: sparse rows.
    task automatic run_frame(input int mode, input int phase);
        int lo, hi, r;
        for (int v = 0; v < 525; v++) begin
            pix(0, v, 1, phase);
            lo = -1; hi = -2;
            if (mode == 0) begin
                if (v == 35)  begin lo = 1;   hi = 300; end
                if (v == 51)  begin lo = 1;   hi = 240; end
                if (v == 514) begin lo = 220; hi = 799; end
            end else if (v >= 35 && v < 515 && ((v - 35) % 16) == 3) begin
                r = (v - 35) / 16;
                if (mode == 1 || (r % 5) == 0 || r == 29) begin lo = 200; hi = 709; end
            end
            for (int h = lo; h <= hi; h++) pix(h, v, 1, phase);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rgb"},   {24'd0, rgb},        32'h00, -1, -1);
        check({tag, "_hsync"}, {31'd0, Hsync},      32'd1,  -1, -1);
        check({tag, "_vsync"}, {31'd0, Vsync},      32'd1,  -1, -1);
        check({tag, "_h_out"}, {22'd0, h_out},      32'd0,  -1, -1);
        check({tag, "_v_out"}, {22'd0, v_out},      32'd0,  -1, -1);
        check({tag, "_rd_en"}, {31'd0, cell_rd_en}, 32'd0,  -1, -1);
        check({tag, "_addr"},  {22'd0, cell_addr},  32'd0,  -1, -1);
    endtask

    initial begin
        logic [7:0] g0;
`ifdef GRID_LINES_EN
        g0 = 8'h49;
`else
        g0 = 8'h00;
`endif
        //          h    v    ph  rgb    rd  addr
        tbl[0] = '{224, 35,  0, 8'h03, 1'b1, 0};
        tbl[1] = '{239, 35,  0, 8'h03, 1'b1, 0};
        tbl[2] = '{240, 35,  0, g0,    1'b1, 1};
        tbl[3] = '{703, 514, 0, 8'hE0, 1'b1, 899};
        tbl[4] = '{704, 514, 0, 8'h92, 1'b0, 0};
        tbl[5] = '{784, 514, 0, 8'h00, 1'b0, 0};
        tbl[6] = '{143, 35,  0, 8'h00, 1'b0, 0};
        tbl[7] = '{144, 35,  0, 8'h92, 1'b0, 0};
        tbl[8] = '{224, 51,  0, g0,    1'b1, 30};
        tbl[9] = '{224, 51,  1, 8'h03, 1'b1, 30};

        rst = 1'b1; pix_en = 1'b0; h_counter = '0; v_counter = '0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        for (int i = 0; i < 900; i++) ram[i] = 2'd0;
        repeat (2) @(negedge clk);

        // Reset held for three pixel ticks, then released.
        period = 4;
        for (int i = 0; i < 3; i++) begin
            pix(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 0, -1);
            check_reset_vals("rst");
        end
        rst = 1'b0;
        pix(0, 0, 0, -1);
        check("rel_rgb",   {24'd0, rgb},   32'h00, 0, 0);
        check("rel_hsync", {31'd0, Hsync}, 32'd1,  0, 0);
        check("rel_vsync", {31'd0, Vsync}, 32'd1,  0, 0);

        // Directed frames against the constant table.
        ram[0] = 2'd1; ram[899] = 2'd2; ram[30] = 2'd0;
        run_frame(0, 0);
        ram[30] = 2'd1;
        run_frame(0, 1);

        // Random board, every row sampled.
        period = 2;
        for (int i = 0; i < 900; i++) ram[i] = 2'($urandom_range(0, 3));
        run_frame(1, -1);

        // Reset in the middle of line 200, then a fresh frame must be correct.
        for (int v = 0; v < 200; v++) pix(0, v, 1, -1);
        for (int h = 0; h < 300; h++) pix(h, 200, 1, -1);
        pend_chk = 0;
        rst = 1'b1;
        for (int h = 300; h < 303; h++) begin
            pix(h, 200, 0, -1);
            check_reset_vals("mid_rst");
        end
        rst = 1'b0;
        pix(303, 200, 0, -1);
        check("mid_rel_rgb", {24'd0, rgb}, 32'h00, 303, 200);
        for (int h = 304; h < 800; h++) pix(h, 200, 0, -1);
        for (int v = 201; v < 525; v++) pix(0, v, 1, -1);
        for (int i = 0; i < 900; i++) ram[i] = 2'($urandom_range(0, 3));
        run_frame(2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
